acc_dma_loader: RTL
===================

// Module: acc_dma_loader
// PURPOSE
//  Bus initiator on the native mem_* interface (valid/ready/addr/wdata/wstrb/rdata) that drives the
//  matmul accelerator without CPU load/store loops. On start: copies the operand block (A then B,
//  packed) from system RAM into the accelerator write window, then copies the result vector from
//  the read window back to RAM. Sits beside the CPU as a second bus master behind the arbiter.
// PARAMETERS
//  ADDR_WRITE   'h1100000  accelerator operand window base (destination of load phase)
//  ADDR_READ    'h1300000  accelerator result window base (source of store phase)
//  R            8          rows per chunk (length of A)
//  S            4          columns per chunk
//  INPUT_WIDTH  8          bits per operand element
//  RESULT_WIDTH 8          bits per result element
//  TIMEOUT      64         max cycles waiting for mem_ready on one access before error
//  Derived: LD_WORDS = INPUT_WIDTH*(R+R*S)/32 (default 10); ST_WORDS = RESULT_WIDTH*S/32 (default 1).
//  Both products must be multiples of 32 bits; elaboration fails otherwise.
// PORTS
//  clk        in   1   system clock
//  resetn     in   1   asynchronous active-low reset
//  start      in   1   1-cycle request; sampled only when idle
//  src_addr   in   32  RAM byte address of packed operand block; captured on accepted start
//  dst_addr   in   32  RAM byte address for result words; captured on accepted start
//  busy       out  1   high from cycle after accepted start until done/error
//  done       out  1   1-cycle pulse on successful completion
//  error      out  1   1-cycle pulse on misaligned address or bus timeout
//  mem_valid  out  1   access request
//  mem_ready  in   1   responder acknowledge
//  mem_addr   out  32  word-aligned byte address
//  mem_wdata  out  32  write data
//  mem_wstrb  out  4   4'b1111 for writes, 4'b0000 for reads
//  mem_rdata  in   32  read data, valid when mem_ready high
// BEHAVIOUR
//  Reset (async, resetn=0): all outputs 0, state IDLE, counters 0; takes effect mid-transfer with no
//   done/error pulse; partially written accelerator contents are left as-is.
//  States: IDLE -> LD_RD -> LD_WR -> (LD_RD | ST_RD) ; ST_RD -> ST_WR -> (ST_RD | FIN) ; FIN -> IDLE.
//   ERR -> IDLE on fault. Word index i counts 0..LD_WORDS-1 in load, 0..ST_WORDS-1 in store.
//  Load: LD_RD reads src+4i, latches rdata; LD_WR writes it to ADDR_WRITE+4i.
//  Store: ST_RD reads ADDR_READ+4i; ST_WR writes it to dst+4i. Addresses wrap mod 2^32.
//  Handshake: mem_valid/addr/wdata/wstrb registered, held stable until mem_ready sampled high; in the
//   handshake cycle mem_valid clears and stays low >=1 cycle before next access (responder ready is
//   registered and lingers one cycle; back-to-back valid would double-count).
//  Per-access cost with a 1-cycle responder: 3 cycles; default job = 22 accesses ~ 66 cycles.
//  Start while busy: ignored, captured addresses unchanged. start with src or dst low 2 bits != 0:
//   error pulse next cycle, no bus activity, busy never rises.
//  Timeout: access counter reaching TIMEOUT with mem_ready low -> mem_valid drops, error pulse, IDLE.
//  FIN: done pulses for exactly 1 cycle, busy falls same cycle; a new start is accepted the next cycle.
//  mem_ready while mem_valid low: ignored.
// STRUCTURE
//  acc_pkg: state enum, window base constants, LD_WORDS/ST_WORDS localparams, word-count checks.
//  Sub-module mem_initiator_port: one read/write access (valid hold, gap cycle, timeout counter,
//   rdata latch) with req/ack/fault handshake to the sequencer FSM in acc_dma_loader.
// TESTING
//  1 Default params, RAM src=0x100 holds bytes 1..40, accel model = real accelerator: start ->
//    accelerator A/B loaded, dst=0x200 receives packed dot products; done within 70 cycles.
//  2 Responder with 5-cycle ready latency -> mem_valid and mem_addr stable 5 cycles each access,
//    >=1 low cycle between accesses, no duplicate writes (count exactly 11 writes).
//  3 start with src=0x102 -> error pulse next cycle, mem_valid never asserted, busy stays 0.
//  4 Accelerator window unmapped (ready never rises) -> error at TIMEOUT=64 cycles after first
//    valid, mem_valid low after, busy low, no done.
//  5 Second start pulse at cycle 10 of a running job with dst=0x300 -> ignored; results go to 0x200.
//  6 resetn low at cycle 20 -> all outputs 0 immediately; after release, fresh start completes
//    normally with correct results.

Source files
------------

// File: rtl/acc_dma_loader_pkg.sv
// Shared types and default geometry for the matmul accelerator DMA loader.
// The operand and result blocks must each be a whole number of 32-bit bus words.
package acc_dma_loader_pkg;

  localparam logic [31:0] ACC_ADDR_WRITE   = 32'h0110_0000;
  localparam logic [31:0] ACC_ADDR_READ    = 32'h0130_0000;
  localparam int unsigned ACC_R            = 8;
  localparam int unsigned ACC_S            = 4;
  localparam int unsigned ACC_INPUT_WIDTH  = 8;
  localparam int unsigned ACC_RESULT_WIDTH = 8;
  localparam int unsigned ACC_TIMEOUT      = 64;

  // The operand block is vector A (R elements) followed by matrix B (R*S elements), packed.
  function automatic int unsigned ld_bits(input int unsigned r, input int unsigned s,
                                          input int unsigned w);
    return w * (r + r * s);
  endfunction

  function automatic int unsigned st_bits(input int unsigned s, input int unsigned w);
    return w * s;
  endfunction

  localparam int unsigned LD_WORDS = ld_bits(ACC_R, ACC_S, ACC_INPUT_WIDTH) / 32;
  localparam int unsigned ST_WORDS = st_bits(ACC_S, ACC_RESULT_WIDTH) / 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_RD,
    S_LD_WR,
    S_ST_RD,
    S_ST_WR,
    S_FIN,
    S_ERR
  } state_e;

endpackage

// File: rtl/acc_dma_loader_mem_initiator_port.sv
// Performs one bus access at a time: holds the request until the responder acknowledges,
// forces a one-cycle idle gap afterwards and gives up after TIMEOUT unanswered cycles.
module acc_dma_loader_mem_initiator_port #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk_i,
  input  logic        resetn_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ack_o,
  output logic        fault_o,
  output logic [31:0] rdata_o,
  output logic        mem_valid_o,
  input  logic        mem_ready_i,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  logic          valid_q;
  logic [CW-1:0] wait_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    wstrb_q;
  logic [31:0]   rdata_q;

  assign ack_o       = valid_q & mem_ready_i;
  assign fault_o     = valid_q & ~mem_ready_i & (wait_q == WAIT_LAST);
  assign rdata_o     = rdata_q;
  assign mem_valid_o = valid_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_wstrb_o = wstrb_q;

  // A new request is only launched while valid is low, which guarantees the idle gap
  // that keeps a lingering ready from acknowledging the following access.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      valid_q <= 1'b0;
      wait_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
    end else if (valid_q) begin
      if (mem_ready_i) begin
        valid_q <= 1'b0;
        rdata_q <= mem_rdata_i;
      end else if (wait_q == WAIT_LAST) begin
        valid_q <= 1'b0;
      end else begin
        wait_q <= wait_q + 1'b1;
      end
    end else if (req_i) begin
      valid_q <= 1'b1;
      wait_q  <= '0;
      addr_q  <= addr_i;
      wdata_q <= we_i ? wdata_i : 32'h0;
      wstrb_q <= we_i ? 4'hF : 4'h0;
    end
  end

endmodule

// File: rtl/acc_dma_loader.sv
// Bus master that copies the packed operand block from RAM into the accelerator and then
// copies the result vector back to RAM, word by word through one access port.
module acc_dma_loader
  import acc_dma_loader_pkg::*;
#(
  parameter logic [31:0] ADDR_WRITE   = ACC_ADDR_WRITE,
  parameter logic [31:0] ADDR_READ    = ACC_ADDR_READ,
  parameter int unsigned R            = ACC_R,
  parameter int unsigned S            = ACC_S,
  parameter int unsigned INPUT_WIDTH  = ACC_INPUT_WIDTH,
  parameter int unsigned RESULT_WIDTH = ACC_RESULT_WIDTH,
  parameter int unsigned TIMEOUT      = ACC_TIMEOUT
) (
  input  logic        clk_i,
  input  logic        resetn_i,
  input  logic        start_i,
  input  logic [31:0] src_addr_i,
  input  logic [31:0] dst_addr_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic        mem_valid_o,
  input  logic        mem_ready_i,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned LD_BITS    = ld_bits(R, S, INPUT_WIDTH);
  localparam int unsigned ST_BITS    = st_bits(S, RESULT_WIDTH);
  localparam int unsigned N_LD_WORDS = LD_BITS / 32;
  localparam int unsigned N_ST_WORDS = ST_BITS / 32;
  localparam logic [15:0] LD_LAST    = 16'(N_LD_WORDS - 1);
  localparam logic [15:0] ST_LAST    = 16'(N_ST_WORDS - 1);

  if ((LD_BITS % 32 != 0) || (ST_BITS % 32 != 0) || (N_LD_WORDS == 0) || (N_ST_WORDS == 0))
  begin : g_geometry_check
    $error("acc_dma_loader: operand and result blocks must be whole 32-bit words");
  end

  state_e      state_q;
  logic [15:0] idx_q;
  logic [31:0] src_q;
  logic [31:0] dst_q;
  logic        busy_q;
  logic        done_q;
  logic        error_q;

  logic [31:0] offset;
  logic [31:0] port_addr;
  logic [31:0] port_rdata;
  logic        port_req;
  logic        port_we;
  logic        port_ack;
  logic        port_fault;

  assign offset  = {14'd0, idx_q, 2'b00};
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign error_o = error_q;

  // Each access state names the address of its word; the write data is always the word
  // just read, held in the port's read latch.
  always_comb begin
    port_req  = 1'b1;
    port_we   = 1'b0;
    port_addr = 32'h0;
    case (state_q)
      S_LD_RD: port_addr = src_q + offset;
      S_LD_WR: begin
        port_addr = ADDR_WRITE + offset;
        port_we   = 1'b1;
      end
      S_ST_RD: port_addr = ADDR_READ + offset;
      S_ST_WR: begin
        port_addr = dst_q + offset;
        port_we   = 1'b1;
      end
      default: port_req = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (src_addr_i[1:0] != 2'b00 || dst_addr_i[1:0] != 2'b00) begin
              error_q <= 1'b1;
            end else begin
              src_q   <= src_addr_i;
              dst_q   <= dst_addr_i;
              idx_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= S_LD_RD;
            end
          end
        end
        S_LD_RD, S_LD_WR, S_ST_RD, S_ST_WR: begin
          if (port_fault) begin
            state_q <= S_ERR;
            busy_q  <= 1'b0;
            error_q <= 1'b1;
          end else if (port_ack) begin
            case (state_q)
              S_LD_RD: state_q <= S_LD_WR;
              S_LD_WR: begin
                if (idx_q == LD_LAST) begin
                  idx_q   <= '0;
                  state_q <= S_ST_RD;
                end else begin
                  idx_q   <= idx_q + 16'd1;
                  state_q <= S_LD_RD;
                end
              end
              S_ST_RD: state_q <= S_ST_WR;
              default: begin
                if (idx_q == ST_LAST) begin
                  state_q <= S_FIN;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                end else begin
                  idx_q   <= idx_q + 16'd1;
                  state_q <= S_ST_RD;
                end
              end
            endcase
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  acc_dma_loader_mem_initiator_port #(
    .TIMEOUT(TIMEOUT)
  ) u_port (
    .clk_i      (clk_i),
    .resetn_i   (resetn_i),
    .req_i      (port_req),
    .we_i       (port_we),
    .addr_i     (port_addr),
    .wdata_i    (port_rdata),
    .ack_o      (port_ack),
    .fault_o    (port_fault),
    .rdata_o    (port_rdata),
    .mem_valid_o(mem_valid_o),
    .mem_ready_i(mem_ready_i),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_wstrb_o(mem_wstrb_o),
    .mem_rdata_i(mem_rdata_i)
  );

endmodule
